sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM address width in bits.
REQ-002 Parameter DATA_W, default 24, SRAM data width in bits.
REQ-003 i_master_clk  in  1  single clock for all logic.
REQ-004 i_reset  in  1  reset, synchronous and active-high.
REQ-005 i_p0_req / i_p0_addr[ADDR_W]  in  video-scanout read request and address (read-only port).
REQ-006 o_p0_ack  out  1  p0 command accepted; o_p0_rvalid / o_p0_rdata[DATA_W]  out  p0 read data valid pulse and data.
REQ-007 i_p1_req / i_p1_we / i_p1_addr[ADDR_W] / i_p1_wdata[DATA_W]  in  renderer read/write request.
REQ-008 o_p1_ack, o_p1_rvalid, o_p1_rdata[DATA_W]  out  as for p0.
REQ-009 i_p2_req / i_p2_addr[ADDR_W] / i_p2_wdata[DATA_W]  in  upload write request (write-only port); o_p2_ack  out  1.
REQ-010 o_sram_address[ADDR_W], o_sram_data_out[DATA_W], o_sram_data_dir_out, o_sram_cs_n, o_sram_oe_n, o_sram_we_n  out  SRAM pins; i_sram_data_in[DATA_W]  in.
REQ-011 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD; arbitration occurs only in IDLE.
REQ-013 Priority: p0 SHALL win whenever i_p0_req is high; otherwise p1 and p2 SHALL be served round-robin via a last-served flag.
REQ-014 On a grant in IDLE (cycle T), the arbiter SHALL register port id, address, write data and direction at the end of T and pulse the granted port's ack for exactly one cycle in T+1.
REQ-015 Read: RD1 (T+1) and RD2 (T+2) SHALL drive cs_n=0, oe_n=0, we_n=1, dir_out=0 with the address stable; i_sram_data_in SHALL be registered at the end of T+2.
REQ-016 Read: the owning port's rvalid SHALL pulse for one cycle in T+3 with rdata valid; the FSM SHALL be in IDLE in T+3 and may grant again there.
REQ-017 Write: WR_SETUP (T+1) SHALL drive cs_n=0, we_n=1, oe_n=1, dir_out=1 with address and data; WR_PULSE (T+2) SHALL additionally drive we_n=0; WR_HOLD (T+3) SHALL return we_n=1 while holding cs_n, address, data and dir_out; IDLE resumes in T+4.
REQ-018 In IDLE, cs_n, oe_n, we_n SHALL be 1 and dir_out 0; address and data_out SHALL hold their last values.
REQ-019 oe_n=0 and dir_out=1 SHALL never be asserted in the same cycle.
REQ-020 A requester SHALL hold req, addr, we and wdata stable until its ack, and SHALL drop req or present the next command by the cycle after ack; the arbiter does not sample req outside IDLE.
REQ-021 Round-robin: after p1 is served the flag SHALL favour p2, and vice versa; p0 grants SHALL NOT change the flag.
REQ-022 An rdata register SHALL hold its value until the next read completes for that port.
REQ-023 i_p1_we=1 SHALL select the write sequence; p0 SHALL always read and p2 SHALL always write.

Reset
REQ-024 While i_reset is high, the FSM SHALL enter IDLE on the next edge, regardless of any access in progress.
REQ-025 Reset values: cs_n=oe_n=we_n=1, dir_out=0, address=0, data_out=0, all acks and rvalids 0, rdata=0, o_busy=0, last-served flag = p2 (p1 is favoured first).
REQ-026 A read aborted by reset SHALL NOT produce rvalid, and an aborted write SHALL release we_n immediately.

Structure
REQ-027 A shared Verilog header sram_defs SHALL hold the state encodings, port ids and the default ADDR_W/DATA_W constants.
REQ-028 The priority/round-robin selection SHALL be a sub-module sram_port_select (reqs + flag in -> one-hot grant out, combinational).

Verification
REQ-029 Single p0 read at 0x00010 with SRAM model data 0xABCDEF -> o_p0_ack in T+1, oe_n low T+1..T+2, o_p0_rvalid in T+3, rdata=0xABCDEF.
REQ-030 p2 write 0x123456 to 0xFFFFF -> dir_out high T+1..T+3, we_n low only in T+2, model memory holds 0x123456.
REQ-031 p1 and p2 requesting continuously with no p0 -> grants alternate p1,p2,p1,p2 starting with p1.
REQ-032 p0, p1 and p2 all requesting in the same IDLE cycle -> p0 granted; p1 is granted next once p0 drops, and the flag is unchanged by the p0 grant.
REQ-033 i_reset asserted in RD2 -> IDLE next cycle, no rvalid, all strobes high; i_reset asserted in WR_PULSE -> we_n=1 next cycle.
REQ-034 Every cycle of a randomized run -> never (oe_n=0 and dir_out=1), and at most one ack high per cycle.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared definitions for the SRAM arbiter slice.
// Holds FSM state and port-id encodings plus default bus widths.
package sram_arbiter_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD1      = 3'd1,
    ST_RD2      = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PORT_P0 = 2'd0,
    PORT_P1 = 2'd1,
    PORT_P2 = 2'd2
  } port_t;

  // Round-robin flag values: which of p1/p2 was served last.
  localparam logic LAST_P1 = 1'b0;
  localparam logic LAST_P2 = 1'b1;

endpackage

// File: rtl/sram_port_select.sv
// sram_port_select: combinational requester selection.
// Ports: i_p0_req/i_p1_req/i_p2_req, i_last_p2 flag -> o_grant one-hot.
import sram_arbiter_pkg::*;

module sram_port_select (
  input  logic       i_p0_req,
  input  logic       i_p1_req,
  input  logic       i_p2_req,
  input  logic       i_last_p2,
  output logic [2:0] o_grant
);

  always_comb begin
    o_grant = 3'b000;
    if (i_p0_req) begin
      o_grant = 3'b001;
    end else if (i_p1_req && i_p2_req) begin
      // Both contend: serve whichever was not served last.
      o_grant = (i_last_p2 == LAST_P2) ? 3'b010 : 3'b100;
    end else if (i_p1_req) begin
      o_grant = 3'b010;
    end else if (i_p2_req) begin
      o_grant = 3'b100;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-port arbiter for an asynchronous SRAM.
// Ports: i_master_clk/i_reset; p0 read, p1 r/w, p2 write (req/ack/rvalid/rdata); SRAM pins; o_busy.
import sram_arbiter_pkg::*;

module sram_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_master_clk,
  input  logic              i_reset,
  input  logic              i_p0_req,
  input  logic [ADDR_W-1:0] i_p0_addr,
  output logic              o_p0_ack,
  output logic              o_p0_rvalid,
  output logic [DATA_W-1:0] o_p0_rdata,
  input  logic              i_p1_req,
  input  logic              i_p1_we,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic              o_p1_ack,
  output logic              o_p1_rvalid,
  output logic [DATA_W-1:0] o_p1_rdata,
  input  logic              i_p2_req,
  input  logic [ADDR_W-1:0] i_p2_addr,
  input  logic [DATA_W-1:0] i_p2_wdata,
  output logic              o_p2_ack,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [DATA_W-1:0] o_sram_data_out,
  output logic              o_sram_data_dir_out,
  output logic              o_sram_cs_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  input  logic [DATA_W-1:0] i_sram_data_in,
  output logic              o_busy
);

  state_t            r_state;
  state_t            w_next;
  port_t             r_port;
  port_t             w_gport;
  logic [2:0]        w_grant_raw;
  logic [2:0]        w_grant;
  logic              w_idle;
  logic              w_gwe;
  logic              w_rd_nx;
  logic              w_wr_nx;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              r_last_p2;
  logic [2:0]        r_ack;
  logic [1:0]        r_rvalid;
  logic              r_cs_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_dir;

  assign w_idle = (r_state == ST_IDLE);

  sram_port_select u_sel (
    .i_p0_req  (i_p0_req),
    .i_p1_req  (i_p1_req),
    .i_p2_req  (i_p2_req),
    .i_last_p2 (r_last_p2),
    .o_grant   (w_grant_raw)
  );

  // Requests are only looked at while idle.
  assign w_grant = w_idle ? w_grant_raw : 3'b000;

  always_comb begin
    w_gport = PORT_P0;
    w_gaddr = i_p0_addr;
    w_gdata = '0;
    w_gwe   = 1'b0;
    unique case (1'b1)
      w_grant[0]: begin
        w_gport = PORT_P0;
        w_gaddr = i_p0_addr;
      end
      w_grant[1]: begin
        w_gport = PORT_P1;
        w_gaddr = i_p1_addr;
        w_gdata = i_p1_wdata;
        w_gwe   = i_p1_we;
      end
      w_grant[2]: begin
        w_gport = PORT_P2;
        w_gaddr = i_p2_addr;
        w_gdata = i_p2_wdata;
        w_gwe   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_grant)
          w_next = w_gwe ? ST_WR_SETUP : ST_RD1;
      end
      ST_RD1:      w_next = ST_RD2;
      ST_RD2:      w_next = ST_IDLE;
      ST_WR_SETUP: w_next = ST_WR_PULSE;
      ST_WR_PULSE: w_next = ST_WR_HOLD;
      ST_WR_HOLD:  w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  assign w_rd_nx = (w_next == ST_RD1) ||
                   (w_next == ST_RD2);
  assign w_wr_nx = (w_next == ST_WR_SETUP) ||
                   (w_next == ST_WR_PULSE) ||
                   (w_next == ST_WR_HOLD);

  always_ff @(posedge i_master_clk) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Strobes are registered from the next state so the pins
  // change cleanly on the clock edge with no decode glitches.
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      r_cs_n <= 1'b1;
      r_oe_n <= 1'b1;
      r_we_n <= 1'b1;
      r_dir  <= 1'b0;
    end else begin
      r_cs_n <= ~(w_rd_nx | w_wr_nx);
      r_oe_n <= ~w_rd_nx;
      r_we_n <= ~(w_next == ST_WR_PULSE);
      r_dir  <= w_wr_nx;
    end
  end

  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      r_port     <= PORT_P0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_last_p2  <= LAST_P2;
      r_ack      <= 3'b000;
      r_rvalid   <= 2'b00;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_ack    <= w_grant;
      r_rvalid <= 2'b00;
      if (|w_grant) begin
        r_port <= w_gport;
        r_addr <= w_gaddr;
        if (w_gwe)
          r_dout <= w_gdata;
      end
      if (w_grant[1])
        r_last_p2 <= LAST_P1;
      else if (w_grant[2])
        r_last_p2 <= LAST_P2;
      if (r_state == ST_RD2) begin
        if (r_port == PORT_P1) begin
          r_rvalid[1] <= 1'b1;
          r_p1_rdata  <= i_sram_data_in;
        end else begin
          r_rvalid[0] <= 1'b1;
          r_p0_rdata  <= i_sram_data_in;
        end
      end
    end
  end

  assign o_p0_ack            = r_ack[0];
  assign o_p1_ack            = r_ack[1];
  assign o_p2_ack            = r_ack[2];
  assign o_p0_rvalid         = r_rvalid[0];
  assign o_p1_rvalid         = r_rvalid[1];
  assign o_p0_rdata          = r_p0_rdata;
  assign o_p1_rdata          = r_p1_rdata;
  assign o_sram_address      = r_addr;
  assign o_sram_data_out     = r_dout;
  assign o_sram_data_dir_out = r_dir;
  assign o_sram_cs_n         = r_cs_n;
  assign o_sram_oe_n         = r_oe_n;
  assign o_sram_we_n         = r_we_n;
  assign o_busy              = ~w_idle;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed + random bench for sram_arbiter.
// Transaction-timeline model plus SRAM pin model; checks every cycle.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0;
  logic [19:0] p0_addr = '0;
  logic        p1_req = 1'b0;
  logic        p1_we = 1'b0;
  logic [19:0] p1_addr = '0;
  logic [23:0] p1_wdata = '0;
  logic        p2_req = 1'b0;
  logic [19:0] p2_addr = '0;
  logic [23:0] p2_wdata = '0;
  logic [23:0] sram_din = '0;

  logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid, p2_ack;
  logic [23:0] p0_rdata, p1_rdata, sram_dout;
  logic [19:0] sram_addr;
  logic        sram_dir, cs_n, oe_n, we_n, busy;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .i_master_clk        (clk),
    .i_reset             (rst),
    .i_p0_req            (p0_req),
    .i_p0_addr           (p0_addr),
    .o_p0_ack            (p0_ack),
    .o_p0_rvalid         (p0_rvalid),
    .o_p0_rdata          (p0_rdata),
    .i_p1_req            (p1_req),
    .i_p1_we             (p1_we),
    .i_p1_addr           (p1_addr),
    .i_p1_wdata          (p1_wdata),
    .o_p1_ack            (p1_ack),
    .o_p1_rvalid         (p1_rvalid),
    .o_p1_rdata          (p1_rdata),
    .i_p2_req            (p2_req),
    .i_p2_addr           (p2_addr),
    .i_p2_wdata          (p2_wdata),
    .o_p2_ack            (p2_ack),
    .o_sram_address      (sram_addr),
    .o_sram_data_out     (sram_dout),
    .o_sram_data_dir_out (sram_dir),
    .o_sram_cs_n         (cs_n),
    .o_sram_oe_n         (oe_n),
    .o_sram_we_n         (we_n),
    .i_sram_data_in      (sram_din),
    .o_busy              (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] dflt(input logic [19:0] a);
    return {4'h0, a} ^ 24'hC3A500;
  endfunction

  // SRAM pin model
  logic [23:0] pin_mem [logic [19:0]];

  function automatic logic [23:0] pin_rd(input logic [19:0] a);
    if (pin_mem.exists(a)) return pin_mem[a];
    return dflt(a);
  endfunction

  always @(negedge clk) begin
    if (cs_n === 1'b0 && we_n === 1'b0)
      pin_mem[sram_addr] = sram_dout;
    sram_din = (oe_n === 1'b0) ? pin_rd(sram_addr) : '0;
  end

  // Request drivers: each port works through its command queue.
  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [23:0] data;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t q2[$];
  int   glog[$];

  always @(negedge clk) begin
    if (p0_ack === 1'b1 && q0.size() > 0) begin
      void'(q0.pop_front());
      glog.push_back(0);
    end
    if (p1_ack === 1'b1 && q1.size() > 0) begin
      void'(q1.pop_front());
      glog.push_back(1);
    end
    if (p2_ack === 1'b1 && q2.size() > 0) begin
      void'(q2.pop_front());
      glog.push_back(2);
    end
    p0_req = (q0.size() > 0);
    if (q0.size() > 0) p0_addr = q0[0].addr;
    p1_req = (q1.size() > 0);
    if (q1.size() > 0) begin
      p1_we    = q1[0].we;
      p1_addr  = q1[0].addr;
      p1_wdata = q1[0].data;
    end
    p2_req = (q2.size() > 0);
    if (q2.size() > 0) begin
      p2_addr  = q2[0].addr;
      p2_wdata = q2[0].data;
    end
  end

  // Model: per-cycle expectation slots filled at grant time.
  typedef struct {
    int          ack;
    bit          rd;
    bit          wr;
    bit          wp;
    bit          rv;
    int          rvp;
    logic [23:0] rvd;
  } slot_t;

  slot_t       ev[8];
  int          cyc = 0;
  int          m_free = 0;
  int          m_last = 2;
  int          m_g;
  int          m_t;
  bit          m_we;
  logic [19:0] m_addr = '0;
  logic [19:0] m_ga;
  logic [23:0] m_gd;
  logic [23:0] m_dout = '0;
  logic [23:0] m_rd0 = '0;
  logic [23:0] m_rd1 = '0;
  logic [23:0] m_mem [logic [19:0]];

  function automatic slot_t idle_slot();
    slot_t s;
    s.ack = -1;
    s.rd  = 0;
    s.wr  = 0;
    s.wp  = 0;
    s.rv  = 0;
    s.rvp = 0;
    s.rvd = '0;
    return s;
  endfunction

  function automatic logic [23:0] mdl_rd(input logic [19:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    m_t = cyc;
    ev[m_t % 8] = idle_slot();
    if (rst) begin
      for (int i = 0; i < 8; i++) ev[i] = idle_slot();
      m_free = m_t + 1;
      m_last = 2;
      m_addr = '0;
      m_dout = '0;
      m_rd0  = '0;
      m_rd1  = '0;
    end else begin
      if (ev[(m_t + 1) % 8].rv) begin
        if (ev[(m_t + 1) % 8].rvp == 1) m_rd1 = ev[(m_t + 1) % 8].rvd;
        else m_rd0 = ev[(m_t + 1) % 8].rvd;
      end
      if (m_t >= m_free) begin
        m_g = -1;
        if (p0_req) m_g = 0;
        else if (p1_req && p2_req) m_g = (m_last == 2) ? 1 : 2;
        else if (p1_req) m_g = 1;
        else if (p2_req) m_g = 2;
        if (m_g >= 0) begin
          m_we = (m_g == 2) || (m_g == 1 && p1_we);
          m_ga = (m_g == 0) ? p0_addr : (m_g == 1) ? p1_addr : p2_addr;
          m_gd = (m_g == 1) ? p1_wdata : p2_wdata;
          ev[(m_t + 1) % 8].ack = m_g;
          m_addr = m_ga;
          if (!m_we) begin
            ev[(m_t + 1) % 8].rd = 1;
            ev[(m_t + 2) % 8].rd = 1;
            ev[(m_t + 3) % 8].rv = 1;
            ev[(m_t + 3) % 8].rvp = m_g;
            ev[(m_t + 3) % 8].rvd = mdl_rd(m_ga);
            m_free = m_t + 3;
          end else begin
            ev[(m_t + 1) % 8].wr = 1;
            ev[(m_t + 2) % 8].wr = 1;
            ev[(m_t + 2) % 8].wp = 1;
            ev[(m_t + 3) % 8].wr = 1;
            m_dout = m_gd;
            m_mem[m_ga] = m_gd;
            m_free = m_t + 4;
          end
          if (m_g != 0) m_last = m_g;
        end
      end
    end
    cyc = m_t + 1;
  end

  // Per-cycle comparison against the model
  slot_t      ce;
  logic [2:0] e_ack;
  logic [1:0] e_rv;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      ce    = ev[cyc % 8];
      e_ack = (ce.ack < 0) ? 3'b000 : 3'(1 << ce.ack);
      e_rv  = ce.rv ? 2'(1 << ce.rvp) : 2'b00;
      chk("acks", {61'd0, p2_ack, p1_ack, p0_ack}, {61'd0, e_ack});
      chk("rvalids", {62'd0, p1_rvalid, p0_rvalid}, {62'd0, e_rv});
      chk("cs_n", {63'd0, cs_n}, {63'd0, ~(ce.rd | ce.wr)});
      chk("oe_n", {63'd0, oe_n}, {63'd0, ~ce.rd});
      chk("we_n", {63'd0, we_n}, {63'd0, ~ce.wp});
      chk("dir", {63'd0, sram_dir}, {63'd0, ce.wr});
      chk("busy", {63'd0, busy}, {63'd0, (cyc < m_free)});
      chk("address", {44'd0, sram_addr}, {44'd0, m_addr});
      if (ce.wr) chk("data_out", {40'd0, sram_dout}, {40'd0, m_dout});
      chk("p0_rdata", {40'd0, p0_rdata}, {40'd0, m_rd0});
      chk("p1_rdata", {40'd0, p1_rdata}, {40'd0, m_rd1});
      chk("oe_dir_excl", {63'd0, !(oe_n === 1'b0 && sram_dir === 1'b1)}, 64'd1);
      chk("one_ack", {63'd0, ($countones({p2_ack, p1_ack, p0_ack}) <= 1)}, 64'd1);
    end
  end

  function automatic logic ackp(input int p);
    if (p == 0) return p0_ack;
    if (p == 1) return p1_ack;
    return p2_ack;
  endfunction

  task automatic wait_ack(input int p, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ackp(p) !== 1'b1 && n < 40);
    chk(nm, {63'd0, ackp(p)}, 64'd1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || q2.size() > 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_log(input string nm, input int exp[$]);
    chk({nm, "_len"}, 64'(glog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(nm, 64'(glog[i]), 64'(exp[i]));
  endtask

  initial begin
    int exp_q[$];
    cmd_t c;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {63'd0, cs_n}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_addr", {44'd0, sram_addr}, 64'd0);
    rst = 1'b0;

    // single p0 read
    pin_mem[20'h00010] = 24'hABCDEF;
    m_mem[20'h00010]   = 24'hABCDEF;
    q0.push_back('{1'b0, 20'h00010, 24'h0});
    wait_ack(0, "p0_ack_T1");
    chk("rd_oe_T1", {63'd0, oe_n}, 64'd0);
    @(negedge clk);
    chk("rd_oe_T2", {63'd0, oe_n}, 64'd0);
    chk("rd_rv_T2", {63'd0, p0_rvalid}, 64'd0);
    @(negedge clk);
    chk("rd_rv_T3", {63'd0, p0_rvalid}, 64'd1);
    chk("rd_data", {40'd0, p0_rdata}, 64'h0ABCDEF);
    chk("rd_oe_T3", {63'd0, oe_n}, 64'd1);
    drain("drain_rd");

    // p2 write to top address
    q2.push_back('{1'b1, 20'hFFFFF, 24'h123456});
    wait_ack(2, "p2_ack_T1");
    chk("wr_dir_T1", {63'd0, sram_dir}, 64'd1);
    chk("wr_we_T1", {63'd0, we_n}, 64'd1);
    @(negedge clk);
    chk("wr_we_T2", {63'd0, we_n}, 64'd0);
    chk("wr_dir_T2", {63'd0, sram_dir}, 64'd1);
    @(negedge clk);
    chk("wr_we_T3", {63'd0, we_n}, 64'd1);
    chk("wr_dir_T3", {63'd0, sram_dir}, 64'd1);
    @(negedge clk);
    chk("wr_dir_T4", {63'd0, sram_dir}, 64'd0);
    chk("wr_mem", {40'd0, pin_mem[20'hFFFFF]}, 64'h0123456);
    drain("drain_wr");

    // p1/p2 contention alternates, p1 first
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      q1.push_back('{i[0], 20'(i + 32), 24'(i * 3 + 5)});
      q2.push_back('{1'b1, 20'(i + 48), 24'(i * 7 + 9)});
    end
    drain("drain_rr");
    exp_q = '{1, 2, 1, 2, 1, 2};
    chk_log("rr_order", exp_q);

    // all three at once: p0 first, flag untouched so p1 next
    glog.delete();
    q0.push_back('{1'b0, 20'h00010, 24'h0});
    q1.push_back('{1'b0, 20'h00021, 24'h0});
    q2.push_back('{1'b1, 20'h00040, 24'h00BEEF});
    drain("drain_pri");
    exp_q = '{0, 1, 2};
    chk_log("pri_order", exp_q);

    // reset during RD2
    q0.push_back('{1'b0, 20'h00010, 24'h0});
    wait_ack(0, "rst_rd_ack");
    @(negedge clk);
    chk("rst_rd_oe_T2", {63'd0, oe_n}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_rv", {63'd0, p0_rvalid}, 64'd0);
    chk("rst_rd_cs", {63'd0, cs_n}, 64'd1);
    chk("rst_rd_oe", {63'd0, oe_n}, 64'd1);
    chk("rst_rd_we", {63'd0, we_n}, 64'd1);
    chk("rst_rd_data", {40'd0, p0_rdata}, 64'd0);
    rst = 1'b0;
    drain("drain_rst_rd");

    // reset during WR_PULSE
    q1.push_back('{1'b1, 20'h00070, 24'h777777});
    wait_ack(1, "rst_wr_ack");
    @(negedge clk);
    chk("rst_wr_we_T2", {63'd0, we_n}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_we", {63'd0, we_n}, 64'd1);
    chk("rst_wr_dir", {63'd0, sram_dir}, 64'd0);
    rst = 1'b0;
    drain("drain_rst_wr");

    // random traffic
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0 && q0.size() < 2) begin
        c = '{1'b0, 20'($urandom_range(0, 15)), 24'h0};
        q0.push_back(c);
      end
      if ($urandom_range(0, 2) == 0 && q1.size() < 2) begin
        c = '{1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), 24'($urandom)};
        q1.push_back(c);
      end
      if ($urandom_range(0, 2) == 0 && q2.size() < 2) begin
        c = '{1'b1, 20'($urandom_range(0, 15)), 24'($urandom)};
        q2.push_back(c);
      end
    end
    drain("drain_rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
